timer: RTL and testbench

TIMER -- requirements
Module: timer

---
 rtl/timer_pkg.sv | 4 +
 rtl/timer_counter.sv | 45 ++++
 rtl/types.svh | 28 ++
 rtl/timer.sv | 117 +++++++++++
 tb/tb_timer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Timer package: wraps the shared register map and types.
package timer_pkg;
`include "types.svh"
endpackage

// File: rtl/timer_counter.sv
// 64-bit mtime counter with a 16-bit prescaler and per-half bus loads.
module timer_counter
    import timer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_enable,
    input  logic [15:0] i_prescale,
    input  logic        i_clr_pre,
    input  logic        i_load_lo,
    input  logic        i_load_hi,
    input  word_t       i_load_data,
    output logic [63:0] o_mtime
);
    logic [15:0] r_pre;
    logic [63:0] r_mtime;
    logic        w_tick;
    logic [63:0] w_inc;

    assign w_tick  = i_enable && (r_pre == i_prescale);
    assign w_inc   = r_mtime + 64'(w_tick);
    assign o_mtime = r_mtime;

    // Prescaler: counts 0..PRESCALE while enabled; any mtime/prescale write restarts it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_pre <= '0;
        else if (i_clr_pre || i_load_lo || i_load_hi || w_tick)
            r_pre <= '0;
        else if (i_enable)
            r_pre <= r_pre + 16'd1;
    end

    // mtime: a bus load wins over the tick; the carry into the other half is dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_mtime <= '0;
        else if (i_load_lo)
            r_mtime <= {r_mtime[63:32], i_load_data};
        else if (i_load_hi)
            r_mtime <= {i_load_data, w_inc[31:0]};
        else
            r_mtime <= w_inc;
    end
endmodule

// File: rtl/types.svh
// Timer register map, CTRL bit positions and shared helper types.
`ifndef TIMER_TYPES_SVH
`define TIMER_TYPES_SVH

typedef logic [31:0] word_t;

// Register index as decoded from addr[4:2]; 6 and 7 are unmapped.
localparam logic [2:0] IDX_MTIME_LO = 3'd0;
localparam logic [2:0] IDX_MTIME_HI = 3'd1;
localparam logic [2:0] IDX_CMP_LO   = 3'd2;
localparam logic [2:0] IDX_CMP_HI   = 3'd3;
localparam logic [2:0] IDX_CTRL     = 3'd4;
localparam logic [2:0] IDX_PRESCALE = 3'd5;

// CTRL bit positions.
localparam int CTRL_EN     = 0;
localparam int CTRL_IRQ_EN = 1;

// Byte-lane merge of a bus write into an existing register value.
function automatic word_t merge_bytes(input word_t old_w, input word_t new_w,
                                      input logic [3:0] sel);
    word_t res;
    for (int b = 0; b < 4; b++)
        res[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return res;
endfunction

`endif

// File: rtl/timer.sv
// Memory-mapped machine timer: bus decode, registers, shadowed mtime read, irq.
module timer
    import timer_pkg::*;
#(
    parameter int          WORD_BITS      = 32,
    parameter logic [15:0] PRESCALE_RESET = 16'd0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [25:0]          addr,
    input  logic [WORD_BITS-1:0] in,
    output logic [WORD_BITS-1:0] out,
    input  logic                 write,
    input  logic [3:0]           select,
    input  logic                 strobe,
    output logic                 ack,
    output logic                 retry,
    output logic                 irq
);
    logic [63:0] w_mtime;
    logic [63:0] r_cmp;
    word_t       r_shadow;
    logic [1:0]  r_ctrl;
    logic [15:0] r_prescale;
    logic        r_ack, r_retry, r_irq;
    word_t       r_out;

    logic [2:0]  w_idx;
    logic        w_mapped, w_wr, w_rd;
    word_t       w_rdata, w_wbase, w_wdata;
    logic        w_unused;

    assign w_unused = ^{addr[25:5], addr[1:0]};
    assign w_idx    = addr[4:2];
    assign w_mapped = (w_idx <= IDX_PRESCALE);
    // A write with no byte enables is acked but must not touch any state.
    assign w_wr     = strobe && write && w_mapped && (select != 4'd0);
    assign w_rd     = strobe && !write && w_mapped;

    // Read mux for the addressed register.
    always_comb begin
        w_rdata = '0;
        case (w_idx)
            IDX_MTIME_LO: w_rdata = w_mtime[31:0];
            IDX_MTIME_HI: w_rdata = r_shadow;
            IDX_CMP_LO:   w_rdata = r_cmp[31:0];
            IDX_CMP_HI:   w_rdata = r_cmp[63:32];
            IDX_CTRL:     w_rdata = {30'd0, r_ctrl};
            IDX_PRESCALE: w_rdata = {16'd0, r_prescale};
            default:      w_rdata = '0;
        endcase
    end

    // Partial writes to MTIME_HI merge into the live upper half, not the shadow.
    assign w_wbase = (w_idx == IDX_MTIME_HI) ? w_mtime[63:32] : w_rdata;
    assign w_wdata = merge_bytes(w_wbase, in, select);

    timer_counter u_counter (
        .clock       (clock),
        .reset       (reset),
        .i_enable    (r_ctrl[CTRL_EN]),
        .i_prescale  (r_prescale),
        .i_clr_pre   (w_wr && (w_idx == IDX_PRESCALE)),
        .i_load_lo   (w_wr && (w_idx == IDX_MTIME_LO)),
        .i_load_hi   (w_wr && (w_idx == IDX_MTIME_HI)),
        .i_load_data (w_wdata),
        .o_mtime     (w_mtime)
    );

    // Bus response: ack/retry one cycle after strobe, out only carries read data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ack   <= 1'b0;
            r_retry <= 1'b0;
            r_out   <= '0;
        end else begin
            r_ack   <= strobe && w_mapped;
            r_retry <= strobe && !w_mapped;
            r_out   <= w_rd ? w_rdata : '0;
        end
    end

    // Software registers and the upper-half shadow captured on a MTIME_LO read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cmp      <= '1;
            r_shadow   <= '0;
            r_ctrl     <= '0;
            r_prescale <= PRESCALE_RESET;
        end else begin
            if (w_rd && (w_idx == IDX_MTIME_LO))
                r_shadow <= w_mtime[63:32];
            if (w_wr) begin
                case (w_idx)
                    IDX_CMP_LO:   r_cmp[31:0]  <= w_wdata;
                    IDX_CMP_HI:   r_cmp[63:32] <= w_wdata;
                    IDX_CTRL:     r_ctrl       <= {w_wdata[CTRL_IRQ_EN], w_wdata[CTRL_EN]};
                    IDX_PRESCALE: r_prescale   <= w_wdata[15:0];
                    default:      ;
                endcase
            end
        end
    end

    // Level interrupt: registered unsigned compare, held until cmp rises or irq_enable drops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_irq <= 1'b0;
        else
            r_irq <= r_ctrl[CTRL_IRQ_EN] && (w_mtime >= r_cmp);
    end

    assign ack   = r_ack;
    assign retry = r_retry;
    assign out   = r_out;
    assign irq   = r_irq;
endmodule

// File: tb/tb_timer.sv
// Self-checking bench for timer: directed table, corner sequences, random vs model.
module tb_timer;
    localparam logic [15:0] PRE_RST = 16'd5;

    logic        clock = 1'b0;
    logic        reset;
    logic [25:0] addr;
    logic [31:0] in, out;
    logic        write, strobe, ack, retry, irq;
    logic [3:0]  select;

    timer #(.WORD_BITS(32), .PRESCALE_RESET(PRE_RST)) dut (
        .clock(clock), .reset(reset), .addr(addr), .in(in), .out(out),
        .write(write), .select(select), .strobe(strobe),
        .ack(ack), .retry(retry), .irq(irq)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [63:0] m_mtime, m_cmp;
    logic [31:0] m_shadow, m_out;
    logic [1:0]  m_ctrl;
    logic [15:0] m_pre;
    int          m_phase;
    logic        m_irq, m_ack, m_retry;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_mtime = 64'd0; m_cmp = '1; m_shadow = 32'd0; m_ctrl = 2'd0; m_pre = PRE_RST;
        m_phase = 0; m_irq = 1'b0; m_ack = 1'b0; m_retry = 1'b0; m_out = 32'd0;
    endtask

    // One clock edge of the spec's behaviour, from the state before the edge.
    task automatic model_step(input logic st, input logic wr, input logic [2:0] idx,
                              input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd, nw;
        logic [63:0] nxt;
        logic        mapped, irq_n;
        mapped = (idx < 3'd6);
        case (idx)
            3'd0: rd = m_mtime[31:0];
            3'd1: rd = m_shadow;
            3'd2: rd = m_cmp[31:0];
            3'd3: rd = m_cmp[63:32];
            3'd4: rd = {30'd0, m_ctrl};
            3'd5: rd = {16'd0, m_pre};
            default: rd = 32'd0;
        endcase
        irq_n = m_ctrl[1] && (m_mtime >= m_cmp);
        // mtime advances once per PRESCALE+1 enabled cycles
        nxt = m_mtime;
        if (m_ctrl[0]) begin
            m_phase++;
            if (m_phase == int'(m_pre) + 1) begin
                nxt = m_mtime + 64'd1;
                m_phase = 0;
            end
        end
        m_ack   = st && mapped;
        m_retry = st && !mapped;
        m_out   = (st && !wr && mapped) ? rd : 32'd0;
        if (st && !wr && idx == 3'd0) m_shadow = m_mtime[63:32];
        if (st && wr && mapped && s != 4'd0) begin
            case (idx)
                3'd0: begin nxt = {m_mtime[63:32], mrg(m_mtime[31:0], d, s)}; m_phase = 0; end
                3'd1: begin nxt = {mrg(m_mtime[63:32], d, s), nxt[31:0]}; m_phase = 0; end
                3'd2: m_cmp[31:0]  = mrg(m_cmp[31:0], d, s);
                3'd3: m_cmp[63:32] = mrg(m_cmp[63:32], d, s);
                3'd4: begin nw = mrg({30'd0, m_ctrl}, d, s); m_ctrl = nw[1:0]; end
                default: begin nw = mrg({16'd0, m_pre}, d, s); m_pre = nw[15:0]; m_phase = 0; end
            endcase
        end
        m_mtime = nxt;
        m_irq   = irq_n;
    endtask

    // Drive one bus cycle, advance the model, check all outputs after the edge.
    task automatic cyc(input logic st, input logic wr, input logic [2:0] idx,
                       input logic [31:0] d, input logic [3:0] s);
        @(negedge clock);
        reset  = 1'b0;
        strobe = st; write = wr; in = d; select = s;
        addr   = {21'($urandom()), idx, 2'($urandom())};
        @(posedge clock);
        model_step(st, wr, idx, d, s);
        #1;
        check("ack", ack, m_ack);
        check("retry", retry, m_retry);
        check("out", out, m_out);
        check("irq", irq, m_irq);
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  idx;
        logic [31:0] d;
        logic [3:0]  s;
        logic        e_ack;
        logic        e_retry;
        logic [31:0] e_out;
    } vec_t;
    vec_t tbl[18];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] prev, first, lo, hi;
        int n;

        tbl[0]  = '{1'b0, 3'd4, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 3'd2, 32'h0,        4'h0, 1'b1, 1'b0, 32'hFFFFFFFF};
        tbl[2]  = '{1'b0, 3'd3, 32'h0,        4'h0, 1'b1, 1'b0, 32'hFFFFFFFF};
        tbl[3]  = '{1'b0, 3'd5, 32'h0,        4'h0, 1'b1, 1'b0, 32'h5};
        tbl[4]  = '{1'b0, 3'd0, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0};
        tbl[5]  = '{1'b1, 3'd2, 32'hAABBCCDD, 4'h5, 1'b1, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 3'd2, 32'h0,        4'h0, 1'b1, 1'b0, 32'hFFBBFFDD};
        tbl[7]  = '{1'b1, 3'd6, 32'h3,        4'hF, 1'b0, 1'b1, 32'h0};
        tbl[8]  = '{1'b0, 3'd4, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0};
        tbl[9]  = '{1'b1, 3'd4, 32'h3,        4'h0, 1'b1, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 3'd4, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0};
        tbl[11] = '{1'b0, 3'd7, 32'h0,        4'h0, 1'b0, 1'b1, 32'h0};
        tbl[12] = '{1'b1, 3'd5, 32'hABCD1234, 4'hF, 1'b1, 1'b0, 32'h0};
        tbl[13] = '{1'b0, 3'd5, 32'h0,        4'h0, 1'b1, 1'b0, 32'h1234};
        tbl[14] = '{1'b1, 3'd4, 32'hFFFFFFFC, 4'hF, 1'b1, 1'b0, 32'h0};
        tbl[15] = '{1'b0, 3'd4, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0};
        tbl[16] = '{1'b1, 3'd3, 32'h0,        4'h3, 1'b1, 1'b0, 32'h0};
        tbl[17] = '{1'b0, 3'd3, 32'h0,        4'h0, 1'b1, 1'b0, 32'hFFFF0000};

        reset = 1'b1; strobe = 1'b0; write = 1'b0; addr = '0; in = '0; select = '0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("rst_ack", ack, 1'b0);
        check("rst_retry", retry, 1'b0);
        check("rst_out", out, 32'd0);
        check("rst_irq", irq, 1'b0);

        // Directed register-map vectors
        for (int i = 0; i < 18; i++) begin
            cyc(1'b1, tbl[i].wr, tbl[i].idx, tbl[i].d, tbl[i].s);
            check("tbl_ack", ack, tbl[i].e_ack);
            check("tbl_retry", retry, tbl[i].e_retry);
            check("tbl_out", out, tbl[i].e_out);
        end

        // PRESCALE = 0: one increment per cycle on back-to-back reads
        cyc(1'b1, 1'b1, 3'd5, 32'd0, 4'hF);
        cyc(1'b1, 1'b1, 3'd4, 32'd1, 4'hF);
        cyc(1'b1, 1'b0, 3'd0, 32'd0, 4'h0);
        prev = out;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 3'd0, 32'd0, 4'h0);
            check("inc_per_cycle", out, prev + 32'd1);
            prev = out;
        end

        // PRESCALE = 3: once every 4 cycles, then frozen when disabled
        cyc(1'b1, 1'b1, 3'd5, 32'd3, 4'hF);
        cyc(1'b1, 1'b0, 3'd0, 32'd0, 4'h0);
        first = out;
        for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, 3'd0, 32'd0, 4'h0);
        check("pre3_rate", out - first, 32'd3);
        cyc(1'b1, 1'b1, 3'd4, 32'd0, 4'hF);
        cyc(1'b1, 1'b0, 3'd0, 32'd0, 4'h0);
        first = out;
        repeat (5) cyc(1'b0, 1'b0, 3'd0, 32'd0, 4'h0);
        cyc(1'b1, 1'b0, 3'd0, 32'd0, 4'h0);
        check("frozen", out, first);

        // LO-to-HI carry with coherent shadowed read
        cyc(1'b1, 1'b1, 3'd5, 32'd0, 4'hF);
        cyc(1'b1, 1'b1, 3'd4, 32'd1, 4'hF);
        cyc(1'b1, 1'b1, 3'd1, 32'd0, 4'hF);
        cyc(1'b1, 1'b1, 3'd0, 32'hFFFFFFFE, 4'hF);
        cyc(1'b0, 1'b0, 3'd0, 32'd0, 4'h0);
        cyc(1'b0, 1'b0, 3'd0, 32'd0, 4'h0);
        cyc(1'b1, 1'b0, 3'd0, 32'd0, 4'h0);
        lo = out;
        cyc(1'b1, 1'b0, 3'd1, 32'd0, 4'h0);
        hi = out;
        check("carry_lo", lo, 32'd0);
        check("carry_hi", hi, 32'd1);

        // irq rise at cmp = 100, drop after raising cmp
        cyc(1'b1, 1'b1, 3'd4, 32'd0, 4'hF);
        cyc(1'b1, 1'b1, 3'd1, 32'd0, 4'hF);
        cyc(1'b1, 1'b1, 3'd0, 32'd0, 4'hF);
        cyc(1'b1, 1'b1, 3'd3, 32'd0, 4'hF);
        cyc(1'b1, 1'b1, 3'd2, 32'd100, 4'hF);
        cyc(1'b1, 1'b1, 3'd5, 32'd0, 4'hF);
        cyc(1'b1, 1'b1, 3'd4, 32'd3, 4'hF);
        n = 0;
        while (irq !== 1'b1 && n < 300) begin
            cyc(1'b0, 1'b0, 3'd0, 32'd0, 4'h0);
            n++;
        end
        check("irq_rise_cycle", n, 101);
        cyc(1'b1, 1'b1, 3'd2, 32'hFFFFFFFF, 4'hF);
        check("irq_hold", irq, 1'b1);
        cyc(1'b0, 1'b0, 3'd0, 32'd0, 4'h0);
        check("irq_drop", irq, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            logic [2:0]  ridx;
            logic [31:0] rd;
            ridx = 3'($urandom_range(0, 7));
            rd   = $urandom();
            if (ridx == 3'd5) rd = rd & 32'd3;
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ridx, rd,
                4'($urandom_range(0, 15)));
        end

        // Async reset mid-count with a response and irq active
        cyc(1'b1, 1'b1, 3'd5, 32'd0, 4'hF);
        cyc(1'b1, 1'b1, 3'd3, 32'd0, 4'hF);
        cyc(1'b1, 1'b1, 3'd2, 32'd0, 4'hF);
        cyc(1'b1, 1'b1, 3'd4, 32'd3, 4'hF);
        cyc(1'b0, 1'b0, 3'd0, 32'd0, 4'h0);
        cyc(1'b1, 1'b0, 3'd0, 32'd0, 4'h0);
        check("pre_rst_ack", ack, 1'b1);
        check("pre_rst_irq", irq, 1'b1);
        #1;
        reset = 1'b1; strobe = 1'b0;
        model_reset();
        #1;
        check("async_ack", ack, 1'b0);
        check("async_retry", retry, 1'b0);
        check("async_out", out, 32'd0);
        check("async_irq", irq, 1'b0);
        @(posedge clock); #1;
        check("held_ack", ack, 1'b0);
        check("held_irq", irq, 1'b0);
        // Strobe in the cycle reset deasserts is serviced
        cyc(1'b1, 1'b0, 3'd3, 32'd0, 4'h0);
        check("post_rst_cmp_hi", out, 32'hFFFFFFFF);
        cyc(1'b1, 1'b0, 3'd5, 32'd0, 4'h0);
        check("post_rst_prescale", out, {16'd0, PRE_RST});
        cyc(1'b1, 1'b0, 3'd0, 32'd0, 4'h0);
        check("post_rst_mtime", out, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
